// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and helpers for the multi-port block RAM
package bram_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTES = DEF_DATA_WIDTH / 8;

  // Byte lane merge used by both the array write and the write-first bypass
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/bram_mp_if.sv
// rtl/bram_mp_if.sv - read/write/clear bus of the multi-port block RAM
interface bram_mp_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NRD        = 2
);
  logic [NRD*ADDR_WIDTH-1:0] raddr;
  logic [NRD-1:0]            re;
  logic [NRD*DATA_WIDTH-1:0] dout;
  logic                      we;
  logic [ADDR_WIDTH-1:0]     waddr;
  logic [DATA_WIDTH-1:0]     din;
  logic [DATA_WIDTH/8-1:0]   wbe;
  logic                      clr;
  logic                      busy;

  modport master (
    output raddr, re, we, waddr, din, wbe, clr,
    input  dout, busy
  );

  modport slave (
    input  raddr, re, we, waddr, din, wbe, clr,
    output dout, busy
  );
endinterface

// File: rtl/bram_clr_seq.sv
// rtl/bram_clr_seq.sv - clear sweep sequencer that zeroes every address after reset or clr
module bram_clr_seq
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  // Terminal detect on all-ones so the counter never wraps back early
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (&cnt) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        RUN: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/bram_mp.sv
// rtl/bram_mp.sv - NRD-read-port block RAM with byte enables and hardware clear
module bram_mp
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int NRD         = 2,
  parameter int WRITE_FIRST = 1
) (
  input  logic      clk,
  input  logic      rstn,
  bram_mp_if.slave  bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] dout_r [NRD];

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ext_we;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [NB-1:0]         wb;
  logic [DATA_WIDTH-1:0] wr_word;

  bram_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_seq (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (bus.clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;

  // A clr request in RUN drops the external write of that cycle
  assign ext_we = bus.we & ~bus.clr & ~busy;
  assign wen    = clr_we | ext_we;
  assign wa     = clr_we ? clr_addr : bus.waddr;
  assign wd     = clr_we ? '0 : bus.din;
  assign wb     = clr_we ? '1 : bus.wbe;

  always_comb begin
    wr_word = '0;
    for (int b = 0; b < NB; b++) begin
      wr_word[b*8 +: 8] = merge_byte(ram[wa][b*8 +: 8], wd[b*8 +: 8], wb[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (wen) begin
      ram[wa] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NRD; k++) begin
        dout_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NRD; k++) begin
        if (bus.re[k]) begin
          if (busy) begin
            dout_r[k] <= '0;
          end else if ((WRITE_FIRST != 0) && ext_we &&
                       (bus.raddr[k*ADDR_WIDTH +: ADDR_WIDTH] == bus.waddr)) begin
            dout_r[k] <= wr_word;
          end else begin
            dout_r[k] <= ram[bus.raddr[k*ADDR_WIDTH +: ADDR_WIDTH]];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_dout
    assign bus.dout[k*DATA_WIDTH +: DATA_WIDTH] = dout_r[k];
  end

endmodule

// File: tb/tb_bram_mp.sv
// tb/tb_bram_mp.sv - directed self-checking bench for bram_mp (write-first and read-first)
module tb_bram_mp;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n;

  always #5 clk = ~clk;

  bram_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NRD(2)) b0 ();
  bram_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NRD(2)) b1 ();

  assign b1.raddr = b0.raddr;
  assign b1.re    = b0.re;
  assign b1.we    = b0.we;
  assign b1.waddr = b0.waddr;
  assign b1.din   = b0.din;
  assign b1.wbe   = b0.wbe;
  assign b1.clr   = b0.clr;

  bram_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NRD(2), .WRITE_FIRST(1)) dut_wf (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b0)
  );

  bram_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NRD(2), .WRITE_FIRST(0)) dut_rf (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    b0.we    = 1'b1;
    b0.waddr = a;
    b0.din   = d;
    b0.wbe   = be;
    @(negedge clk);
    b0.we    = 1'b0;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    b0.re    = 2'b11;
    b0.raddr = {a1, a0};
    @(negedge clk);
    b0.re    = 2'b00;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!b0.busy) break;
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    rstn     = 1'b0;
    b0.raddr = '0;
    b0.re    = '0;
    b0.we    = 1'b0;
    b0.waddr = '0;
    b0.din   = '0;
    b0.wbe   = '0;
    b0.clr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(b0.busy), 64'd1);
    chk("rst_dout_wf", 64'(b0.dout), 64'd0);
    chk("rst_dout_rf", 64'(b1.dout), 64'd0);

    rstn = 1'b1;
    count_busy(n);
    chk("init_sweep_len", 64'(n), 64'd32);
    chk("init_busy_rf", 64'(b1.busy), 64'd0);

    for (int a = 0; a < 32; a++) begin
      rd2(5'(a), 5'(31 - a));
      chk("zero_after_init", 64'(b0.dout), 64'd0);
    end

    wr(5'd3, 32'hDEADBEEF, 4'b1111);
    wr(5'd3, 32'h11223344, 4'b0101);
    rd2(5'd3, 5'd3);
    chk("byte_merge_p0", 64'(b0.dout[31:0]), 64'hDE22BE44);
    chk("byte_merge_p1", 64'(b0.dout[63:32]), 64'hDE22BE44);

    // Same-cycle write and read of address 7 on both ports
    wr(5'd7, 32'hAAAAAAAA, 4'b1111);
    b0.we = 1'b1; b0.waddr = 5'd7; b0.din = 32'h55555555; b0.wbe = 4'b1111;
    b0.re = 2'b11; b0.raddr = {5'd7, 5'd7};
    @(negedge clk);
    b0.we = 1'b0; b0.re = 2'b00;
    chk("coll_wf", 64'(b0.dout), {32'h55555555, 32'h55555555});
    chk("coll_rf", 64'(b1.dout), {32'hAAAAAAAA, 32'hAAAAAAAA});
    rd2(5'd7, 5'd7);
    chk("coll_rf_next", 64'(b1.dout), {32'h55555555, 32'h55555555});

    b0.we = 1'b1; b0.waddr = 5'd7; b0.din = 32'h12345678; b0.wbe = 4'b0011;
    b0.re = 2'b11; b0.raddr = {5'd7, 5'd7};
    @(negedge clk);
    b0.we = 1'b0; b0.re = 2'b00;
    chk("coll_part_wf", 64'(b0.dout[31:0]), 64'h55555678);
    chk("coll_part_rf", 64'(b1.dout[31:0]), 64'h55555555);

    wr(5'd1, 32'h1, 4'b1111);
    wr(5'd2, 32'h2, 4'b1111);
    wr(5'd1, 32'hFFFFFFFF, 4'b0000);
    rd2(5'd1, 5'd2);
    chk("p0_addr1", 64'(b0.dout[31:0]), 64'h1);
    chk("p1_addr2", 64'(b0.dout[63:32]), 64'h2);
    b0.re = 2'b01; b0.raddr = {5'd7, 5'd3};
    @(negedge clk);
    b0.re = 2'b00;
    chk("re01_p0_upd", 64'(b0.dout[31:0]), 64'hDE22BE44);
    chk("re01_p1_hold", 64'(b0.dout[63:32]), 64'h2);

    // clr with a same-cycle write, then activity during the sweep
    wr(5'd4, 32'h44, 4'b1111);
    b0.clr = 1'b1;
    b0.we = 1'b1; b0.waddr = 5'd4; b0.din = 32'hCAFEF00D; b0.wbe = 4'b1111;
    @(negedge clk);
    b0.clr = 1'b0; b0.we = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!b0.busy) break;
      n++;
      b0.re  = (n == 3) ? 2'b11 : 2'b00;
      b0.clr = (n == 8);
      if (n == 10) chk("clear_read_zero", 64'(b0.dout), 64'd0);
      if (n == 20) begin
        b0.we = 1'b1; b0.waddr = 5'd1; b0.din = 32'hBAD0BAD0; b0.wbe = 4'b1111;
      end else begin
        b0.we = 1'b0;
      end
      @(negedge clk);
    end
    b0.re = 2'b00; b0.we = 1'b0; b0.clr = 1'b0;
    chk("clr_sweep_len", 64'(n), 64'd32);

    wr(5'd9, 32'h99, 4'b1111);
    rd2(5'd4, 5'd9);
    chk("clr_drop_we", 64'(b0.dout[31:0]), 64'h0);
    chk("first_write", 64'(b0.dout[63:32]), 64'h99);
    rd2(5'd1, 5'd3);
    chk("busy_write_drop", 64'(b0.dout), 64'd0);

    // Reset in the middle of a sweep
    rd2(5'd9, 5'd9);
    b0.clr = 1'b1;
    @(negedge clk);
    b0.clr = 1'b0;
    repeat (10) @(negedge clk);
    chk("clear_hold_re0", 64'(b0.dout), {32'h99, 32'h99});
    rstn = 1'b0;
    #1;
    chk("midrst_busy", 64'(b0.busy), 64'd1);
    chk("midrst_dout", 64'(b0.dout), 64'd0);
    @(negedge clk);
    chk("midrst_dout2", 64'(b0.dout), 64'd0);
    rstn = 1'b1;
    count_busy(n);
    chk("midrst_sweep_len", 64'(n), 64'd32);
    rd2(5'd9, 5'd7);
    chk("midrst_zeroed", 64'(b0.dout), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
